// File: rtl/perceptron_layer.sv
// M-neuron perceptron layer: time-multiplexed MAC over an N-element vector,
// per-neuron bias, run-time activation and valid/ready handshakes.
module perceptron_layer #(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_we,
  input  logic [$clog2(M)-1:0]   w_neuron,
  input  logic [$clog2(N+1)-1:0] w_index,
  input  logic [DW-1:0]          w_data,
  output logic                   w_err,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW*N-1:0]        x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW*M-1:0]        y,
  output logic [M-1:0]           fire
);

  localparam int ACCW = 2*DW + $clog2(N) + 1;
  localparam int CW   = $clog2(N);
  localparam int NW   = $clog2(N+1);
  localparam int MW   = $clog2(M);
  localparam int MW1  = MW + 1;

  localparam logic [NW-1:0]          N_IDX      = NW'(N);
  localparam logic [MW:0]            M_LIM      = MW1'(M);
  localparam logic [CW-1:0]          CNT_LAST   = CW'(N-1);
  localparam logic signed [ACCW-1:0] SMAX       = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN       = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]   ONE_FX     = {{(DW-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [DW-1:0]   NEG_ONE_FX = -ONE_FX;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, ACT = 2'd2, HOLD = 2'd3} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [1:0]             mode_q;
  logic signed [DW-1:0]   x_q   [N];
  logic signed [DW-1:0]   w_q   [M][N];
  logic signed [DW-1:0]   b_q   [M];
  logic signed [ACCW-1:0] acc_q [M];
  logic [DW*M-1:0]        y_q;
  logic [M-1:0]           fire_q;
  logic                   out_valid_q;
  logic                   in_ready_q;
  logic                   w_err_q;

  logic signed [2*DW-1:0] prod_s [M];
  logic signed [ACCW-1:0] sum_s  [M];
  logic signed [ACCW-1:0] acc_d  [M];
  logic signed [DW-1:0]   act_s  [M];
  logic [DW*M-1:0]        y_d;
  logic [M-1:0]           fire_d;

  function automatic logic signed [DW-1:0] sat(input logic signed [ACCW-1:0] v);
    logic signed [DW-1:0] r;
    if (v > SMAX) r = SMAX[DW-1:0];
    else if (v < SMIN) r = SMIN[DW-1:0];
    else r = v[DW-1:0];
    return r;
  endfunction

  function automatic logic signed [DW-1:0] activate(input logic signed [ACCW-1:0] s,
                                                    input logic [1:0] md);
    logic signed [DW-1:0] r;
    logic                 neg;
    logic                 pos;
    neg = s[ACCW-1];
    pos = !neg && (s != '0);
    case (md)
      2'd0:    r = pos ? ONE_FX : '0;
      2'd1:    r = pos ? sat(s) : '0;
      2'd2:    r = sat(s);
      2'd3:    r = neg ? NEG_ONE_FX : ONE_FX;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Per-neuron MAC step, bias/rescale and activation
  always_comb begin
    y_d    = '0;
    fire_d = '0;
    for (int j = 0; j < M; j++) begin
      prod_s[j] = (2*DW)'(x_q[cnt_q]) * (2*DW)'(w_q[j][cnt_q]);
      acc_d[j]  = acc_q[j] + ACCW'(prod_s[j]);
      // bias aligned to the product scale; >>> rounds toward -inf
      sum_s[j]  = (acc_q[j] + (ACCW'(b_q[j]) <<< FRAC)) >>> FRAC;
      act_s[j]  = activate(sum_s[j], mode_q);
      y_d[DW*j +: DW] = act_s[j];
      fire_d[j] = !act_s[j][DW-1] && (act_s[j] != '0);
    end
  end

  // Control FSM, weight/bias store and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 2'd0;
      y_q         <= '0;
      fire_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      w_err_q     <= 1'b0;
      for (int j = 0; j < M; j++) begin
        b_q[j]   <= '0;
        acc_q[j] <= '0;
        for (int i = 0; i < N; i++) w_q[j][i] <= '0;
      end
      for (int i = 0; i < N; i++) x_q[i] <= '0;
    end else begin
      if (w_we) begin
        if (state_q == IDLE || state_q == HOLD) begin
          if ({1'b0, w_neuron} < M_LIM) begin
            if (w_index < N_IDX) w_q[w_neuron][w_index[CW-1:0]] <= w_data;
            else if (w_index == N_IDX) b_q[w_neuron] <= w_data;
          end
        end else begin
          w_err_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            for (int i = 0; i < N; i++) x_q[i] <= x[DW*i +: DW];
            for (int j = 0; j < M; j++) acc_q[j] <= '0;
            mode_q     <= mode;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MAC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        MAC: begin
          for (int j = 0; j < M; j++) acc_q[j] <= acc_d[j];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_q <= ACT;
        end
        ACT: begin
          y_q         <= y_d;
          fire_q      <= fire_d;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign fire      = fire_q;
  assign w_err     = w_err_q;

endmodule

// File: tb/tb_perceptron_layer.sv
// Directed self-checking bench for perceptron_layer with N=4, M=2, DW=16, FRAC=8.
module tb_perceptron_layer;

  localparam int N = 4;
  localparam int M = 2;
  localparam int DW = 16;
  localparam int FRAC = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            w_we = 1'b0;
  logic [0:0]      w_neuron = '0;
  logic [2:0]      w_index = '0;
  logic [DW-1:0]   w_data = '0;
  logic            w_err;
  logic [1:0]      mode = 2'd0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW*N-1:0] x = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW*M-1:0] y;
  logic [M-1:0]    fire;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  localparam logic [63:0] X1 = {16'h0080, 16'hFF00, 16'h0200, 16'h0100};
  localparam logic [63:0] X2 = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
  localparam logic [63:0] XS = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};

  perceptron_layer #(.N(N), .M(M), .DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst),
    .w_we(w_we), .w_neuron(w_neuron), .w_index(w_index), .w_data(w_data), .w_err(w_err),
    .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .fire(fire)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at a negedge; the write lands on the following posedge.
  task automatic do_write(input int n, input int idx, input logic [15:0] d);
    w_neuron = 1'(n);
    w_index  = 3'(idx);
    w_data   = d;
    w_we     = 1'b1;
    @(negedge clk);
    w_we     = 1'b0;
  endtask

  task automatic load_w(input logic [15:0] wv, input logic [15:0] b0, input logic [15:0] b1);
    for (int j = 0; j < M; j++)
      for (int i = 0; i < N; i++) do_write(j, i, wv);
    do_write(0, N, b0);
    do_write(1, N, b1);
  endtask

  // Returns the number of negedges from the accept edge until out_valid is seen.
  task automatic send_vec(input logic [63:0] xv, input logic [1:0] md, output int lat);
    int t;
    x = xv;
    mode = md;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode = ~md;
    x = '0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL rst_y: got %h expected 00000000", y); end
    checks++; if (fire !== 2'b00) begin errors++; $display("FAIL rst_fire: got %b expected 00", fire); end
    checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL rst_w_err: got %b expected 0", w_err); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_linear;
    int lat;
    load_w(16'h0100, 16'h0000, 16'h0000);
    send_vec(X1, 2'd2, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL lin_latency: got %0d expected 6", lat); end
    checks++; if (y !== 32'h0280_0280) begin errors++; $display("FAIL lin_y: got %h expected 02800280", y); end
    checks++; if (fire !== 2'b11) begin errors++; $display("FAIL lin_fire: got %b expected 11", fire); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lin_ov_clear: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lin_ready_back: got %b expected 1", in_ready); end
  endtask

  task automatic test_modes;
    int lat;
    do_write(1, N, 16'hFC00);
    send_vec(X1, 2'd1, lat);
    checks++; if (y !== 32'h0000_0280) begin errors++; $display("FAIL relu_y: got %h expected 00000280", y); end
    checks++; if (fire !== 2'b01) begin errors++; $display("FAIL relu_fire: got %b expected 01", fire); end
    release_out();
    send_vec(X1, 2'd0, lat);
    checks++; if (y !== 32'h0000_0100) begin errors++; $display("FAIL step_y: got %h expected 00000100", y); end
    checks++; if (fire !== 2'b01) begin errors++; $display("FAIL step_fire: got %b expected 01", fire); end
    release_out();
    send_vec(X1, 2'd3, lat);
    checks++; if (y !== 32'hFF00_0100) begin errors++; $display("FAIL sign_y: got %h expected ff000100", y); end
    checks++; if (fire !== 2'b01) begin errors++; $display("FAIL sign_fire: got %b expected 01", fire); end
    release_out();
  endtask

  task automatic test_saturation;
    int lat;
    load_w(16'h7FFF, 16'h0000, 16'h0000);
    send_vec(XS, 2'd2, lat);
    checks++; if (y !== 32'h7FFF_7FFF) begin errors++; $display("FAIL sat_pos_y: got %h expected 7fff7fff", y); end
    checks++; if (fire !== 2'b11) begin errors++; $display("FAIL sat_pos_fire: got %b expected 11", fire); end
    release_out();
    load_w(16'h8000, 16'h0000, 16'h0000);
    send_vec(XS, 2'd2, lat);
    checks++; if (y !== 32'h8000_8000) begin errors++; $display("FAIL sat_neg_y: got %h expected 80008000", y); end
    checks++; if (fire !== 2'b00) begin errors++; $display("FAIL sat_neg_fire: got %b expected 00", fire); end
    release_out();
  endtask

  task automatic test_back_to_back;
    int lat;
    int t;
    int n_acc;
    int acc_t [3];
    load_w(16'h0100, 16'h0000, 16'h0000);
    send_vec(X1, 2'd2, lat);
    x = X2;
    mode = 2'd2;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", k, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready); end
      checks++; if (y !== 32'h0280_0280) begin errors++; $display("FAIL bp_y[%0d]: got %h expected 02800280", k, y); end
      checks++; if (fire !== 2'b11) begin errors++; $display("FAIL bp_fire[%0d]: got %b expected 11", k, fire); end
    end
    out_ready = 1'b1;
    n_acc = 0;
    t = 0;
    while (n_acc < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (in_ready) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
    end
    checks++; if (n_acc !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", n_acc); end
    if (n_acc == 3) begin
      checks++; if (acc_t[1] - acc_t[0] !== 7) begin errors++; $display("FAIL b2b_gap0: got %0d expected 7", acc_t[1] - acc_t[0]); end
      checks++; if (acc_t[2] - acc_t[1] !== 7) begin errors++; $display("FAIL b2b_gap1: got %0d expected 7", acc_t[2] - acc_t[1]); end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++; if (y !== 32'h0400_0400) begin errors++; $display("FAIL b2b_y: got %h expected 04000400", y); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_illegal_write;
    int lat;
    int t;
    checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL werr_initial: got %b expected 0", w_err); end
    do_write(0, 5, 16'h7777);
    checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL werr_oob_index: got %b expected 0", w_err); end
    x = X1;
    mode = 2'd2;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    do_write(0, 0, 16'h7000);
    checks++; if (w_err !== 1'b1) begin errors++; $display("FAIL werr_mac: got %b expected 1", w_err); end
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++; if (y !== 32'h0280_0280) begin errors++; $display("FAIL werr_weight_kept: got %h expected 02800280", y); end
    do_write(0, N, 16'h0100);
    checks++; if (w_err !== 1'b1) begin errors++; $display("FAIL werr_sticky: got %b expected 1", w_err); end
    release_out();
    send_vec(X1, 2'd2, lat);
    checks++; if (y !== 32'h0280_0380) begin errors++; $display("FAIL hold_write_y: got %h expected 02800380", y); end
    release_out();
  endtask

  task automatic test_reset_mid;
    int lat;
    int t;
    x = X1;
    mode = 2'd2;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
    checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL mid_w_err: got %b expected 0", w_err); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_back: got %b expected 1", in_ready); end
    send_vec(X1, 2'd2, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL mid_latency: got %0d expected 6", lat); end
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL mid_zero_y: got %h expected 00000000", y); end
    checks++; if (fire !== 2'b00) begin errors++; $display("FAIL mid_zero_fire: got %b expected 00", fire); end
    checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL mid_w_err_after: got %b expected 0", w_err); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_linear();
    test_modes();
    test_saturation();
    test_back_to_back();
    test_illegal_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
